// File: rtl/receptor_alineador_pkg.sv
// Shared 8b/10b line constants, thresholds and encodings for the receive aligner
// and the matching transmitter.
package receptor_alineador_pkg;

  // Symbols are held with the first received bit (a) in bit 0.
  localparam logic [9:0] K28_5_RDN  = 10'b0101111100;
  localparam logic [9:0] K28_5_RDP  = 10'b1010000011;
  localparam logic [5:0] K28_6B_RDN = 6'b001111;

  localparam logic [1:0] LOCK_TH   = 2'd3;
  localparam logic [2:0] UNLOCK_TH = 3'd4;

  localparam logic [1:0] DS_8  = 2'b00;
  localparam logic [1:0] DS_16 = 2'b01;
  localparam logic [1:0] DS_32 = 2'b10;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ALIGNING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // 5b/6b code for RD-, written abcdei with a in the MSB.
  function automatic logic [5:0] enc6_rdn(input logic [4:0] x);
    case (x)
      5'd0:  enc6_rdn = 6'b100111;  5'd1:  enc6_rdn = 6'b011101;
      5'd2:  enc6_rdn = 6'b101101;  5'd3:  enc6_rdn = 6'b110001;
      5'd4:  enc6_rdn = 6'b110101;  5'd5:  enc6_rdn = 6'b101001;
      5'd6:  enc6_rdn = 6'b011001;  5'd7:  enc6_rdn = 6'b111000;
      5'd8:  enc6_rdn = 6'b111001;  5'd9:  enc6_rdn = 6'b100101;
      5'd10: enc6_rdn = 6'b010101;  5'd11: enc6_rdn = 6'b110100;
      5'd12: enc6_rdn = 6'b001101;  5'd13: enc6_rdn = 6'b101100;
      5'd14: enc6_rdn = 6'b011100;  5'd15: enc6_rdn = 6'b010111;
      5'd16: enc6_rdn = 6'b011011;  5'd17: enc6_rdn = 6'b100011;
      5'd18: enc6_rdn = 6'b010011;  5'd19: enc6_rdn = 6'b110010;
      5'd20: enc6_rdn = 6'b001011;  5'd21: enc6_rdn = 6'b101010;
      5'd22: enc6_rdn = 6'b011010;  5'd23: enc6_rdn = 6'b111010;
      5'd24: enc6_rdn = 6'b110011;  5'd25: enc6_rdn = 6'b100110;
      5'd26: enc6_rdn = 6'b010110;  5'd27: enc6_rdn = 6'b110110;
      5'd28: enc6_rdn = 6'b001110;  5'd29: enc6_rdn = 6'b101110;
      5'd30: enc6_rdn = 6'b011110;  default: enc6_rdn = 6'b101011;
    endcase
  endfunction

  // 3b/4b code for RD-, written fghj with f in the MSB.
  function automatic logic [3:0] enc4_rdn(input logic [2:0] y);
    case (y)
      3'd0: enc4_rdn = 4'b1011;  3'd1: enc4_rdn = 4'b1001;
      3'd2: enc4_rdn = 4'b0101;  3'd3: enc4_rdn = 4'b1100;
      3'd4: enc4_rdn = 4'b1101;  3'd5: enc4_rdn = 4'b1010;
      3'd6: enc4_rdn = 4'b0110;  default: enc4_rdn = 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/receptor_alineador_decoder.sv
// Combinational 10b-to-8b decode; accepts either running-disparity form and
// flags anything outside the code table as invalid.
module decoder_10b8b
  import receptor_alineador_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic [7:0] byte_o,
  output logic       k_o,
  output logic       inv_o
);

  logic [5:0] abcdei, c6;
  logic [3:0] fghj, c4;
  logic [4:0] x5;
  logic [2:0] y3;
  logic       hit6, hit4;

  always_comb begin
    abcdei = {sym_i[0], sym_i[1], sym_i[2], sym_i[3], sym_i[4], sym_i[5]};
    fghj   = {sym_i[6], sym_i[7], sym_i[8], sym_i[9]};
    c6 = '0; c4 = '0; x5 = '0; y3 = '0;
    hit6 = 1'b0; hit4 = 1'b0; k_o = 1'b0;
    if (abcdei == K28_6B_RDN || abcdei == ~K28_6B_RDN) begin
      hit6 = 1'b1; x5 = 5'd28; k_o = 1'b1;
      // K28 flips the neutral 4b codes on RD+, so undo that before lookup.
      if (abcdei != K28_6B_RDN) fghj = ~fghj;
    end else begin
      for (int i = 0; i < 32; i++) begin
        c6 = enc6_rdn(5'(i));
        if (abcdei == c6 || (abcdei == ~c6 && (i == 7 || $countones(c6) != 3))) begin
          hit6 = 1'b1; x5 = 5'(i);
        end
      end
    end
    if (fghj == 4'b0111 || fghj == 4'b1000) begin
      hit4 = 1'b1; y3 = 3'd7;
    end
    for (int j = 0; j < 8; j++) begin
      c4 = enc4_rdn(3'(j));
      if (fghj == c4 || (fghj == ~c4 && (j == 3 || $countones(c4) != 2))) begin
        hit4 = 1'b1; y3 = 3'(j);
      end
    end
    byte_o = {y3, x5};
    inv_o  = ~(hit6 & hit4);
  end

endmodule

// File: rtl/receptor_alineador.sv
// Serial 8b/10b receiver: comma alignment, symbol decode and 8/16/32-bit word gather.
//   state    | meaning
//   UNLOCKED | hunting for a comma at any bit phase
//   ALIGNING | counting commas on the chosen boundary
//   LOCKED   | decoding boundary symbols and gathering bytes
module receptor_alineador
  import receptor_alineador_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        serialIn,
  input  logic        RxElecIdle,
  input  logic [1:0]  dataS,
  output logic [7:0]  dataOut8,
  output logic [15:0] dataOut16,
  output logic [31:0] dataOut32,
  output logic [3:0]  kOut,
  output logic        valid,
  output logic        locked,
  output logic        symErr
);

  state_t      state_q, state_d;
  logic [9:0]  sh_q, sh_d;
  logic [3:0]  phase_q, phase_d;
  logic [1:0]  comma_cnt_q, comma_cnt_d;
  logic [2:0]  err_cnt_q, err_cnt_d;
  logic [1:0]  ptr_q, ptr_d, ptr_eff;
  logic [1:0]  ds_q, ds_d;
  logic [23:0] acc_q, acc_d;
  logic [2:0]  kacc_q, kacc_d;
  logic [7:0]  d8_q, d8_d;
  logic [15:0] d16_q, d16_d;
  logic [31:0] d32_q, d32_d;
  logic [3:0]  k_q, k_d;
  logic        valid_q, valid_d, symerr_q, symerr_d;

  logic [7:0] dec_byte;
  logic       dec_k, dec_inv, comma, at_bnd;
  logic [1:0] ds_sel, last_idx;

  decoder_10b8b u_dec (
    .sym_i  (sh_q),
    .byte_o (dec_byte),
    .k_o    (dec_k),
    .inv_o  (dec_inv)
  );

  assign comma    = (sh_q == K28_5_RDN) || (sh_q == K28_5_RDP);
  assign at_bnd   = (phase_q == 4'd9);
  assign ds_sel   = (dataS == DS_16 || dataS == DS_32) ? dataS : DS_8;
  assign last_idx = (ds_sel == DS_32) ? 2'd3 : (ds_sel == DS_16) ? 2'd1 : 2'd0;

  always_comb begin
    state_d = state_q; sh_d = sh_q; phase_d = phase_q;
    comma_cnt_d = comma_cnt_q; err_cnt_d = err_cnt_q; ptr_d = ptr_q; ds_d = ds_q;
    acc_d = acc_q; kacc_d = kacc_q;
    d8_d = d8_q; d16_d = d16_q; d32_d = d32_q; k_d = k_q;
    valid_d = 1'b0; symerr_d = 1'b0;
    ptr_eff = (ds_sel != ds_q) ? 2'd0 : ptr_q;
    if (enb) begin
      sh_d    = {serialIn, sh_q[9:1]};
      phase_d = at_bnd ? 4'd0 : phase_q + 4'd1;
      ds_d    = ds_sel;
      ptr_d   = ptr_eff;
      if (RxElecIdle) begin
        state_d = ST_UNLOCKED; comma_cnt_d = '0; err_cnt_d = '0;
      end else begin
        case (state_q)
          ST_UNLOCKED: begin
            if (comma) begin
              phase_d = 4'd0; comma_cnt_d = 2'd1; state_d = ST_ALIGNING;
            end
          end
          ST_ALIGNING: begin
            if (comma && at_bnd) begin
              comma_cnt_d = comma_cnt_q + 2'd1;
              if (comma_cnt_q + 2'd1 == LOCK_TH) begin
                state_d = ST_LOCKED; comma_cnt_d = '0; err_cnt_d = '0;
              end
            end else if (comma) begin
              phase_d = 4'd0; comma_cnt_d = 2'd1;
            end else if (at_bnd) begin
              state_d = ST_UNLOCKED; comma_cnt_d = '0;
            end
          end
          ST_LOCKED: begin
            if (at_bnd && dec_inv) begin
              symerr_d = 1'b1; ptr_d = 2'd0;
              err_cnt_d = err_cnt_q + 3'd1;
              if (err_cnt_q + 3'd1 == UNLOCK_TH) begin
                state_d = ST_UNLOCKED; err_cnt_d = '0;
              end
            end else if (at_bnd) begin
              err_cnt_d = '0;
              // K28.5 in lock is idle fill; everything else is payload.
              if (!comma) begin
                if (ptr_eff == last_idx) begin
                  valid_d = 1'b1; ptr_d = 2'd0;
                  case (ds_sel)
                    DS_16: begin
                      d16_d = {dec_byte, acc_q[7:0]}; k_d = {2'b00, dec_k, kacc_q[0]};
                    end
                    DS_32: begin
                      d32_d = {dec_byte, acc_q}; k_d = {dec_k, kacc_q};
                    end
                    default: begin
                      d8_d = dec_byte; k_d = {3'b000, dec_k};
                    end
                  endcase
                end else begin
                  ptr_d = ptr_eff + 2'd1;
                  case (ptr_eff)
                    2'd0:    begin acc_d[7:0]   = dec_byte; kacc_d[0] = dec_k; end
                    2'd1:    begin acc_d[15:8]  = dec_byte; kacc_d[1] = dec_k; end
                    default: begin acc_d[23:16] = dec_byte; kacc_d[2] = dec_k; end
                  endcase
                end
              end
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
      if (state_d != ST_LOCKED) ptr_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCKED; sh_q <= '0; phase_q <= '0;
      comma_cnt_q <= '0; err_cnt_q <= '0; ptr_q <= '0; ds_q <= '0;
      acc_q <= '0; kacc_q <= '0; d8_q <= '0; d16_q <= '0; d32_q <= '0;
      k_q <= '0; valid_q <= 1'b0; symerr_q <= 1'b0;
    end else begin
      state_q <= state_d; sh_q <= sh_d; phase_q <= phase_d;
      comma_cnt_q <= comma_cnt_d; err_cnt_q <= err_cnt_d; ptr_q <= ptr_d; ds_q <= ds_d;
      acc_q <= acc_d; kacc_q <= kacc_d; d8_q <= d8_d; d16_q <= d16_d; d32_q <= d32_d;
      k_q <= k_d; valid_q <= valid_d; symerr_q <= symerr_d;
    end
  end

  assign dataOut8  = d8_q;
  assign dataOut16 = d16_q;
  assign dataOut32 = d32_q;
  assign kOut      = k_q;
  assign valid     = valid_q;
  assign symErr    = symerr_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_receptor_alineador.sv
// Directed bench for receptor_alineador; symbols are written a..j in transmission order.
module tb_receptor_alineador;

  logic        clk = 1'b0;
  logic        rst, enb, serialIn, RxElecIdle;
  logic [1:0]  dataS;
  logic [7:0]  dataOut8;
  logic [15:0] dataOut16;
  logic [31:0] dataOut32;
  logic [3:0]  kOut;
  logic        valid, locked, symErr;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] D21_5 = 10'b1010101010;
  localparam logic [9:0] D10_2 = 10'b0101010101;
  localparam logic [9:0] ZSYM  = 10'b0000000000;

  int checks = 0, failures = 0;
  int cyc = 0, valid_cnt = 0, valid_cyc = 0, symerr_cnt = 0;
  int lock_rise_cyc = 0, lock_fall_cyc = 0;
  int last, t0, v0, s0;
  logic locked_prev = 1'b0;

  receptor_alineador dut (
    .clk(clk), .rst(rst), .enb(enb), .serialIn(serialIn), .RxElecIdle(RxElecIdle),
    .dataS(dataS), .dataOut8(dataOut8), .dataOut16(dataOut16), .dataOut32(dataOut32),
    .kOut(kOut), .valid(valid), .locked(locked), .symErr(symErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin valid_cnt++; valid_cyc = cyc; end
    if (symErr) symerr_cnt++;
    if (locked && !locked_prev) lock_rise_cyc = cyc;
    if (!locked && locked_prev) lock_fall_cyc = cyc;
    locked_prev = locked;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serialIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_aj(input logic [9:0] aj);
    for (int i = 9; i >= 0; i--) send_bit(aj[i]);
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; serialIn = 1'b0; RxElecIdle = 1'b0; dataS = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_d8", dataOut8, 0);
    check_eq("rst_d16", dataOut16, 0);
    check_eq("rst_d32", dataOut32, 0);
    check_eq("rst_k", kOut, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_symerr", symErr, 0);
    rst = 1'b0;

    // 8-bit lock and data
    repeat (3) send_aj(K_RDN);
    last = cyc;
    send_aj(D21_5);
    check_eq("lock8_rise", lock_rise_cyc, last + 1);
    last = cyc;
    send_aj(K_RDN);
    check_eq("d8_vcnt", valid_cnt, 1);
    check_eq("d8_vcyc", valid_cyc, last + 1);
    check_eq("d8_data", dataOut8, 8'hB5);
    check_eq("d8_k", kOut, 0);
    check_eq("d8_locked", locked, 1);

    // 32-bit gather with idle comma dropped
    dataS = 2'b10; v0 = valid_cnt;
    send_aj(D10_2); send_aj(D21_5); send_aj(K_RDN); send_aj(D10_2); send_aj(D21_5);
    last = cyc;
    send_aj(K_RDN);
    check_eq("d32_vcnt", valid_cnt - v0, 1);
    check_eq("d32_vcyc", valid_cyc, last + 1);
    check_eq("d32_data", dataOut32, 32'hB54AB54A);
    check_eq("d32_k", kOut, 0);
    check_eq("d32_hold8", dataOut8, 8'hB5);

    // Error run broken by one good symbol, then four errors drop lock
    dataS = 2'b00; v0 = valid_cnt; s0 = symerr_cnt;
    repeat (3) send_aj(ZSYM);
    send_aj(D21_5);
    repeat (3) send_aj(ZSYM);
    send_bit(1'b0);
    check_eq("err3_locked", locked, 1);
    repeat (9) send_bit(1'b0);
    last = cyc;
    send_aj(ZSYM);
    check_eq("err_symcnt", symerr_cnt - s0, 7);
    check_eq("err_fall", lock_fall_cyc, last + 1);
    check_eq("err_vcnt", valid_cnt - v0, 1);

    // Realignment: off-boundary comma restarts the count
    v0 = valid_cnt;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    send_aj(K_RDN);
    send_bit(1); send_bit(0); send_bit(1);
    repeat (3) send_aj(K_RDN);
    last = cyc;
    send_aj(K_RDN);
    check_eq("realign_rise", lock_rise_cyc, last + 1);
    check_eq("realign_vcnt", valid_cnt - v0, 0);

    // Electrical idle drops lock on the next clock
    check_eq("idle_pre", locked, 1);
    RxElecIdle = 1'b1;
    send_bit(1'b0);
    check_eq("idle_locked", locked, 0);
    RxElecIdle = 1'b0;

    // Reset in the middle of a 16-bit word
    dataS = 2'b01;
    repeat (3) send_aj(K_RDN);
    send_aj(D21_5);
    for (int i = 9; i >= 6; i--) send_bit(D10_2[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mrst_d8", dataOut8, 0);
    check_eq("mrst_d16", dataOut16, 0);
    check_eq("mrst_d32", dataOut32, 0);
    check_eq("mrst_k", kOut, 0);
    check_eq("mrst_valid", valid, 0);
    check_eq("mrst_locked", locked, 0);
    check_eq("mrst_symerr", symErr, 0);
    v0 = valid_cnt;
    send_aj(D10_2); send_aj(D21_5); send_aj(K_RDN);
    check_eq("mrst_noval", valid_cnt - v0, 0);
    repeat (3) send_aj(K_RDN);
    send_aj(D10_2); send_aj(D21_5);
    last = cyc;
    send_aj(K_RDN);
    check_eq("d16_vcnt", valid_cnt - v0, 1);
    check_eq("d16_vcyc", valid_cyc, last + 1);
    check_eq("d16_data", dataOut16, 16'hB54A);

    // Enable pause: same word, five clocks later
    t0 = cyc;
    send_aj(D21_5); send_aj(D10_2); send_aj(K_RDN);
    check_eq("enb_ref_lat", valid_cyc - t0, 21);
    check_eq("enb_ref_data", dataOut16, 16'h4AB5);
    t0 = cyc; v0 = valid_cnt;
    send_aj(D21_5);
    for (int i = 9; i >= 5; i--) send_bit(D10_2[i]);
    enb = 1'b0;
    repeat (5) begin
      serialIn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    enb = 1'b1;
    for (int i = 4; i >= 0; i--) send_bit(D10_2[i]);
    send_aj(K_RDN);
    check_eq("enb_lat", valid_cyc - t0, 26);
    check_eq("enb_data", dataOut16, 16'h4AB5);
    check_eq("enb_vcnt", valid_cnt - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
